uart_rx_buffer: RTL and testbench

Receive-side buffer that sits directly downstream of the TR1402A-style UART receiver. It drains each received character, with its error flags, into a show-ahead FIFO and acknowledges the UART with a one-cycle read strobe. It presents a valid/ready stream to the VT52 terminal core. Optionally, it generates XOFF/XON flow-control requests toward the transmit path as the FIFO fills and drains.

---
 rtl/uart_buf_pkg.sv | 25 ++
 rtl/uart_rx_buffer_fc.sv | 86 ++++++++
 rtl/uart_rx_buffer.sv | 158 +++++++++++++++
 tb/tb_uart_rx_buffer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_buf_pkg.sv
// Shared constants and state types for the UART receive buffer and its
// XON/XOFF flow-control FSM.
package uart_buf_pkg;

    localparam logic [7:0] XON_CHAR  = 8'h11;
    localparam logic [7:0] XOFF_CHAR = 8'h13;

    // Bit positions inside the 3-bit error field stored with each character
    localparam int ERR_OVR = 2;
    localparam int ERR_FRM = 1;
    localparam int ERR_PAR = 0;

    typedef enum logic {
        CAP_IDLE,
        CAP_ACK
    } cap_state_e;

    typedef enum logic [1:0] {
        FC_ON,
        FC_SEND_XOFF,
        FC_OFF,
        FC_SEND_XON
    } fc_state_e;

endpackage

// File: rtl/uart_rx_buffer_fc.sv
// XON/XOFF flow-control FSM: requests XOFF when the receive FIFO fills and
// XON once it has drained, one byte request at a time.
//
//   state        | meaning
//   FC_ON        | peer may send; watching for count >= XOFF level
//   FC_SEND_XOFF | XOFF byte requested, waiting for the TX mux ack
//   FC_OFF       | XOFF sent; watching for count <= XON level
//   FC_SEND_XON  | XON byte requested, waiting for the TX mux ack
module uart_rx_buffer_fc
    import uart_buf_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int XOFF_LEVEL = 12,
    parameter int XON_LEVEL  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DEPTH_LOG2:0]   count,
    input  logic                  fc_ack,
    output logic                  fc_req,
    output logic [7:0]            fc_byte,
    output logic                  fc_paused
);

    localparam logic [DEPTH_LOG2:0] XOFF_CNT = XOFF_LEVEL[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] XON_CNT  = XON_LEVEL[DEPTH_LOG2:0];

    fc_state_e state_q;
    logic      req_q;
    logic      paused_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FC_ON;
            req_q    <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            case (state_q)
                FC_ON: begin
                    if (count >= XOFF_CNT) begin
                        state_q <= FC_SEND_XOFF;
                        req_q   <= 1'b1;
                    end
                end
                FC_SEND_XOFF: begin
                    if (fc_ack) begin
                        state_q  <= FC_OFF;
                        req_q    <= 1'b0;
                        paused_q <= 1'b1;
                    end
                end
                FC_OFF: begin
                    if (count <= XON_CNT) begin
                        state_q <= FC_SEND_XON;
                        req_q   <= 1'b1;
                    end
                end
                FC_SEND_XON: begin
                    if (fc_ack) begin
                        state_q  <= FC_ON;
                        req_q    <= 1'b0;
                        paused_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= FC_ON;
                    req_q    <= 1'b0;
                    paused_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        fc_byte = 8'h00;
        case (state_q)
            FC_SEND_XOFF: fc_byte = XOFF_CHAR;
            FC_SEND_XON:  fc_byte = XON_CHAR;
            default:      fc_byte = 8'h00;
        endcase
    end

    assign fc_req    = req_q;
    assign fc_paused = paused_q;

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: captures characters and error flags into a show-ahead
// FIFO. XON/XOFF generation is built only with UART_RX_BUFFER_XONXOFF_EN.
module uart_rx_buffer
    import uart_buf_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int XOFF_LEVEL = 12,
    parameter int XON_LEVEL  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_rx_ready,
    input  logic [7:0]            uart_rx_data,
    input  logic                  uart_overrun,
    input  logic                  uart_framing,
    input  logic                  uart_parity,
    output logic                  uart_rx_read,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic [2:0]            out_err,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [7:0]            frame_err_cnt,
    input  logic                  clr_status,
    output logic                  fc_req,
    output logic [7:0]            fc_byte,
    input  logic                  fc_ack,
    output logic                  fc_paused
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];

    cap_state_e              cap_state_q;
    logic                    rx_read_q;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    out_valid_q;
    logic                    overflow_q;
    logic [7:0]              frm_cnt_q;
    logic [10:0]             mem_q [DEPTH];
    logic [2:0]              err_in;
    logic                    cap_idle, full, do_pop, do_push, do_drop, do_frm;

    assign cap_idle = (cap_state_q == CAP_IDLE);
    assign full     = (count_q == FULL_CNT);
    assign do_pop   = out_valid_q && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push  = cap_idle && uart_rx_ready && (!full || do_pop);
    assign do_drop  = cap_idle && uart_rx_ready && full && !do_pop;
    assign do_frm   = cap_idle && !uart_rx_ready && uart_framing;

    always_comb begin
        err_in          = 3'b000;
        err_in[ERR_OVR] = uart_overrun;
        err_in[ERR_FRM] = uart_framing;
        err_in[ERR_PAR] = uart_parity;
    end

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // ACK is a dead cycle while the UART drops its ready/error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_state_q <= CAP_IDLE;
            rx_read_q   <= 1'b0;
        end else begin
            case (cap_state_q)
                CAP_IDLE: begin
                    if (uart_rx_ready || uart_framing) begin
                        cap_state_q <= CAP_ACK;
                        rx_read_q   <= 1'b1;
                    end
                end
                default: begin
                    cap_state_q <= CAP_IDLE;
                    rx_read_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            frm_cnt_q   <= 8'h00;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_d;
            out_valid_q <= (count_d != '0);

            if (do_drop) begin
                overflow_q <= 1'b1;
            end else if (clr_status) begin
                overflow_q <= 1'b0;
            end

            // A framing event coinciding with a clear leaves a count of one.
            if (do_frm) begin
                if (clr_status) begin
                    frm_cnt_q <= 8'h01;
                end else if (frm_cnt_q != 8'hFF) begin
                    frm_cnt_q <= frm_cnt_q + 1'b1;
                end
            end else if (clr_status) begin
                frm_cnt_q <= 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= {err_in, uart_rx_data};
    end

    assign out_data      = mem_q[rd_ptr_q][7:0];
    assign out_err       = mem_q[rd_ptr_q][10:8];
    assign uart_rx_read  = rx_read_q;
    assign out_valid     = out_valid_q;
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign frame_err_cnt = frm_cnt_q;

`ifdef UART_RX_BUFFER_XONXOFF_EN
    uart_rx_buffer_fc #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .XOFF_LEVEL (XOFF_LEVEL),
        .XON_LEVEL  (XON_LEVEL)
    ) u_fc (
        .clk       (clk),
        .rst_n     (rst_n),
        .count     (count_q),
        .fc_ack    (fc_ack),
        .fc_req    (fc_req),
        .fc_byte   (fc_byte),
        .fc_paused (fc_paused)
    );
`else
    logic unused_fc;
    assign unused_fc = ^{fc_ack, XOFF_LEVEL[0], XON_LEVEL[0]};
    assign fc_req    = 1'b0;
    assign fc_byte   = 8'h00;
    assign fc_paused = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Randomized self-checking bench for uart_rx_buffer against a queue-based
// reference model of the capture, FIFO, status and flow-control rules.
module tb_uart_rx_buffer;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;
    localparam int XOFF_LEVEL = 12;
    localparam int XON_LEVEL  = 4;
`ifdef UART_RX_BUFFER_XONXOFF_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic uart_rx_ready, uart_overrun, uart_framing, uart_parity;
    logic [7:0] uart_rx_data;
    logic uart_rx_read, out_valid, out_ready, overflow, clr_status;
    logic [7:0] out_data, frame_err_cnt, fc_byte;
    logic [2:0] out_err;
    logic [DEPTH_LOG2:0] count;
    logic fc_req, fc_ack, fc_paused;

    int checks = 0;
    int errors = 0;

    logic [10:0] m_q[$];
    bit          m_busy, m_read, m_ovf, m_req, m_paused;
    int          m_frm;
    logic [7:0]  m_byte;

    always #5 clk = ~clk;

    uart_rx_buffer #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .XOFF_LEVEL (XOFF_LEVEL),
        .XON_LEVEL  (XON_LEVEL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart_rx_ready (uart_rx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_overrun  (uart_overrun),
        .uart_framing  (uart_framing),
        .uart_parity   (uart_parity),
        .uart_rx_read  (uart_rx_read),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_err       (out_err),
        .out_ready     (out_ready),
        .count         (count),
        .overflow      (overflow),
        .frame_err_cnt (frame_err_cnt),
        .clr_status    (clr_status),
        .fc_req        (fc_req),
        .fc_byte       (fc_byte),
        .fc_ack        (fc_ack),
        .fc_paused     (fc_paused)
    );

    task automatic model_reset();
        m_q.delete();
        m_busy = 0; m_read = 0; m_ovf = 0; m_frm = 0;
        m_req = 0; m_paused = 0; m_byte = 8'h00;
    endtask

    // Called at a negedge: drive one cycle, advance the model, return at the next negedge.
    task automatic drive_cycle(input bit rdy, input logic [7:0] d, input logic [2:0] fl,
                               input bit pop, input bit clr, input bit ack);
        int  prev;
        bit  set_ovf, set_frm;
        uart_rx_ready = rdy; uart_rx_data = d;
        uart_overrun = fl[2]; uart_framing = fl[1]; uart_parity = fl[0];
        out_ready = pop; clr_status = clr; fc_ack = ack;
        @(posedge clk);
        prev = m_q.size();
        set_ovf = 0; set_frm = 0; m_read = 0;
        if (pop && m_q.size() > 0) void'(m_q.pop_front());
        if (!m_busy && rdy) begin
            if (m_q.size() < DEPTH) m_q.push_back({fl, d});
            else set_ovf = 1;
            m_read = 1;
        end else if (!m_busy && fl[1]) begin
            set_frm = 1;
            m_read = 1;
        end
        m_busy = m_read;
        if (set_ovf) m_ovf = 1; else if (clr) m_ovf = 0;
        if (set_frm) m_frm = clr ? 1 : (m_frm < 255 ? m_frm + 1 : 255);
        else if (clr) m_frm = 0;
        if (FC_EN) begin
            if (!m_req && !m_paused) begin
                if (prev >= XOFF_LEVEL) begin m_req = 1; m_byte = 8'h13; end
            end else if (m_req && !m_paused) begin
                if (ack) begin m_req = 0; m_paused = 1; m_byte = 8'h00; end
            end else if (!m_req && m_paused) begin
                if (prev <= XON_LEVEL) begin m_req = 1; m_byte = 8'h11; end
            end else begin
                if (ack) begin m_req = 0; m_paused = 0; m_byte = 8'h00; end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        uart_rx_ready = 0; uart_rx_data = 0; uart_overrun = 0; uart_framing = 0;
        uart_parity = 0; out_ready = 0; clr_status = 0; fc_ack = 0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++; if (uart_rx_read !== 1'b0) begin errors++; $display("FAIL reset_read got %b exp 0", uart_rx_read); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (overflow !== 1'b0 || frame_err_cnt !== 8'h00) begin errors++; $display("FAIL reset_status got %b/%0d exp 0/0", overflow, frame_err_cnt); end
        checks++; if (fc_req !== 1'b0 || fc_byte !== 8'h00 || fc_paused !== 1'b0) begin errors++; $display("FAIL reset_fc got %b/%h/%b exp 0/00/0", fc_req, fc_byte, fc_paused); end
        rst_n = 1'b1;
        // Reset during ACK: the character must be captured again afterwards
        drive_cycle(1, 8'h55, 3'b000, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        checks++; if (count !== '0 || uart_rx_read !== 1'b0) begin errors++; $display("FAIL reset_mid_ack got %0d/%b exp 0/0", count, uart_rx_read); end
        rst_n = 1'b1;
        drive_cycle(1, 8'h55, 3'b000, 0, 0, 0);
        checks++; if (count !== 5'd1 || out_data !== 8'h55 || uart_rx_read !== 1'b1) begin errors++; $display("FAIL reset_recapture got %0d/%h/%b exp 1/55/1", count, out_data, uart_rx_read); end
        drive_cycle(0, 8'h00, 3'b000, 1, 0, 0);
        checks++; if (int'(count) !== m_q.size() || count !== '0) begin errors++; $display("FAIL reset_pop got %0d exp 0", count); end
    endtask

    task automatic test_single();
        drive_cycle(1, 8'h41, 3'b000, 0, 0, 0);
        checks++; if (uart_rx_read !== 1'b1) begin errors++; $display("FAIL single_read_hi got %b exp 1", uart_rx_read); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h41 || out_err !== 3'b000) begin errors++; $display("FAIL single_head got %b/%h/%b exp 1/41/000", out_valid, out_data, out_err); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
        drive_cycle(0, 8'h00, 3'b000, 0, 0, 0);
        checks++; if (uart_rx_read !== 1'b0 || count !== 5'd1) begin errors++; $display("FAIL single_read_lo got %b/%0d exp 0/1", uart_rx_read, count); end
        drive_cycle(0, 8'h00, 3'b000, 1, 0, 0);
        checks++; if (out_valid !== 1'b0 || count !== '0) begin errors++; $display("FAIL single_pop got %b/%0d exp 0/0", out_valid, count); end
    endtask

    task automatic test_parity();
        drive_cycle(1, 8'h7E, 3'b001, 0, 0, 0);
        drive_cycle(0, 8'h00, 3'b000, 0, 0, 0);
        checks++; if (out_data !== 8'h7E || out_err !== 3'b001) begin errors++; $display("FAIL parity_head got %h/%b exp 7e/001", out_data, out_err); end
        drive_cycle(0, 8'h00, 3'b000, 1, 0, 0);
        checks++; if (out_valid !== 1'b0 || count !== '0) begin errors++; $display("FAIL parity_pop got %b/%0d exp 0/0", out_valid, count); end
    endtask

    task automatic test_flow();
        for (int i = 0; i < XOFF_LEVEL; i++) begin
            drive_cycle(1, 8'($urandom), 3'b000, 0, 0, 0);
            drive_cycle(0, 8'h00, 3'b000, 0, 0, 0);
        end
        checks++; if (fc_req !== m_req || fc_byte !== m_byte) begin errors++; $display("FAIL flow_xoff_model got %b/%h exp %b/%h", fc_req, fc_byte, m_req, m_byte); end
`ifdef UART_RX_BUFFER_XONXOFF_EN
        checks++; if (fc_req !== 1'b1 || fc_byte !== 8'h13) begin errors++; $display("FAIL flow_xoff got %b/%h exp 1/13", fc_req, fc_byte); end
`endif
        drive_cycle(0, 8'h00, 3'b000, 0, 0, 1);
        checks++; if (fc_req !== m_req || fc_paused !== m_paused) begin errors++; $display("FAIL flow_paused_model got %b/%b exp %b/%b", fc_req, fc_paused, m_req, m_paused); end
`ifdef UART_RX_BUFFER_XONXOFF_EN
        checks++; if (fc_req !== 1'b0 || fc_paused !== 1'b1) begin errors++; $display("FAIL flow_paused got %b/%b exp 0/1", fc_req, fc_paused); end
`endif
        for (int i = 0; i < XOFF_LEVEL - XON_LEVEL; i++) drive_cycle(0, 8'h00, 3'b000, 1, 0, 0);
        drive_cycle(0, 8'h00, 3'b000, 0, 0, 0);
        checks++; if (fc_byte !== m_byte || int'(count) !== XON_LEVEL) begin errors++; $display("FAIL flow_xon_model got %h/%0d exp %h/%0d", fc_byte, count, m_byte, XON_LEVEL); end
`ifdef UART_RX_BUFFER_XONXOFF_EN
        checks++; if (fc_req !== 1'b1 || fc_byte !== 8'h11) begin errors++; $display("FAIL flow_xon got %b/%h exp 1/11", fc_req, fc_byte); end
`endif
        drive_cycle(0, 8'h00, 3'b000, 0, 0, 1);
        checks++; if (fc_paused !== 1'b0 || fc_req !== 1'b0) begin errors++; $display("FAIL flow_resume got %b/%b exp 0/0", fc_paused, fc_req); end
        for (int i = 0; i < XON_LEVEL; i++) drive_cycle(0, 8'h00, 3'b000, 1, 0, 0);
        checks++; if (count !== '0) begin errors++; $display("FAIL flow_drain got %0d exp 0", count); end
    endtask

    task automatic test_framing();
        drive_cycle(0, 8'h00, 3'b010, 0, 0, 0);
        checks++; if (uart_rx_read !== 1'b1 || frame_err_cnt !== 8'd1 || count !== '0) begin errors++; $display("FAIL frame_one got %b/%0d/%0d exp 1/1/0", uart_rx_read, frame_err_cnt, count); end
        drive_cycle(0, 8'h00, 3'b000, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            drive_cycle(0, 8'h00, 3'b010, 0, 0, 0);
            drive_cycle(0, 8'h00, 3'b000, 0, 0, 0);
        end
        checks++; if (frame_err_cnt !== 8'd255 || int'(frame_err_cnt) !== m_frm) begin errors++; $display("FAIL frame_sat got %0d exp 255", frame_err_cnt); end
        drive_cycle(0, 8'h00, 3'b010, 0, 1, 0);
        checks++; if (frame_err_cnt !== 8'd1) begin errors++; $display("FAIL frame_clr_set got %0d exp 1", frame_err_cnt); end
        drive_cycle(0, 8'h00, 3'b000, 0, 1, 0);
        checks++; if (frame_err_cnt !== 8'd0) begin errors++; $display("FAIL frame_clr got %0d exp 0", frame_err_cnt); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive_cycle(1, 8'($urandom), 3'($urandom), 0, 0, 0);
            drive_cycle(0, 8'h00, 3'b000, 0, 0, 0);
        end
        checks++; if (int'(count) !== DEPTH || overflow !== 1'b1) begin errors++; $display("FAIL ovf_full got %0d/%b exp 16/1", count, overflow); end
        checks++; if ({out_err, out_data} !== m_q[0]) begin errors++; $display("FAIL ovf_head got %h exp %h", {out_err, out_data}, m_q[0]); end
        drive_cycle(0, 8'h00, 3'b000, 0, 1, 0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", overflow); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1, 8'($urandom), 3'($urandom), 1, 0, 0);
            checks++; if (int'(count) !== DEPTH || uart_rx_read !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL b2b_full got %0d/%b/%b exp 16/1/0", count, uart_rx_read, overflow); end
            checks++; if ({out_err, out_data} !== m_q[0]) begin errors++; $display("FAIL b2b_head got %h exp %h", {out_err, out_data}, m_q[0]); end
            drive_cycle(0, 8'h00, 3'b000, 0, 0, 0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if ({out_err, out_data} !== m_q[0]) begin errors++; $display("FAIL b2b_order got %h exp %h", {out_err, out_data}, m_q[0]); end
            drive_cycle(0, 8'h00, 3'b000, 1, 0, 0);
        end
        checks++; if (out_valid !== 1'b0 || count !== '0) begin errors++; $display("FAIL b2b_empty got %b/%0d exp 0/0", out_valid, count); end
    endtask

    task automatic test_random();
        bit rdy;
        logic [2:0] fl;
        for (int i = 0; i < 2000; i++) begin
            rdy = ($urandom_range(0, 2) == 0);
            fl  = rdy ? 3'($urandom) : {1'b0, ($urandom_range(0, 7) == 0), 1'b0};
            drive_cycle(rdy, 8'($urandom), fl, ($urandom_range(0, 2) == 0),
                        ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0));
            checks++;
            if (uart_rx_read !== m_read || int'(count) !== m_q.size() || out_valid !== (m_q.size() != 0)) begin
                errors++; $display("FAIL rand_fifo cyc %0d got %b/%0d/%b exp %b/%0d/%b", i, uart_rx_read, count, out_valid, m_read, m_q.size(), m_q.size() != 0);
            end
            checks++;
            if (m_q.size() != 0 && {out_err, out_data} !== m_q[0]) begin
                errors++; $display("FAIL rand_head cyc %0d got %h exp %h", i, {out_err, out_data}, m_q[0]);
            end
            checks++;
            if (overflow !== m_ovf || int'(frame_err_cnt) !== m_frm) begin
                errors++; $display("FAIL rand_status cyc %0d got %b/%0d exp %b/%0d", i, overflow, frame_err_cnt, m_ovf, m_frm);
            end
            checks++;
            if (fc_req !== m_req || fc_byte !== m_byte || fc_paused !== m_paused) begin
                errors++; $display("FAIL rand_fc cyc %0d got %b/%h/%b exp %b/%h/%b", i, fc_req, fc_byte, fc_paused, m_req, m_byte, m_paused);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_flow();
        test_framing();
        test_overflow();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
